// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: iterative CORDIC engine, UNROLL micro-rotations per cycle.
// Rotation mode (mode=0) drives z to 0; vectoring mode (mode=1) drives y to 0.
// x/y: two's complement, 1.0 = 2^(WIDTH-3). z: binary angle, 2^WIDTH = 2*pi.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, mode              one-cycle request (taken only when idle), op select
//   x_in, y_in, z_in         signed operands, captured on accepted start
//   busy, done               busy from accept through done cycle, done pulse
//   x_out, y_out, z_out      signed results, held until the next done
// No gain compensation: x/y come out scaled by K ~= 1.6468.

// One micro-rotation. Shift index and ROM angle come from the engine.
module cordic_iter_stage #(
  parameter int WIDTH = 18,
  parameter int SW    = 4
) (
  input  logic                    mode,
  input  logic [SW-1:0]           sh,
  input  logic signed [WIDTH-1:0] atan,
  input  logic signed [WIDTH+1:0] x_i,
  input  logic signed [WIDTH+1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  output logic signed [WIDTH+1:0] x_o,
  output logic signed [WIDTH+1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);
  logic                    dpos;
  logic signed [WIDTH+1:0] xs, ys;

  // d=+1 when rotating counter-clockwise: z>=0 (rotation) or y<0 (vectoring)
  assign dpos = mode ? y_i[WIDTH+1] : ~z_i[WIDTH-1];
  assign xs   = x_i >>> sh;
  assign ys   = y_i >>> sh;
  assign x_o  = dpos ? x_i - ys : x_i + ys;
  assign y_o  = dpos ? y_i + xs : y_i - xs;
  assign z_o  = dpos ? z_i - atan : z_i + atan;
endmodule

module cordic_iter_engine #(
  parameter int WIDTH  = 18,
  parameter int ITERS  = 12,
  parameter int UNROLL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);
  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(1) << (WIDTH - 2);

  if (ITERS % UNROLL != 0) begin : g_bad_unroll
    $error("ITERS must be a multiple of UNROLL");
  end
  if (ITERS > WIDTH - 2) begin : g_bad_iters
    $error("ITERS must not exceed WIDTH-2");
  end

  // round(atan(2^-i) * 2^WIDTH / (2*pi)), evaluated at elaboration
  function automatic logic signed [WIDTH-1:0] atan_val(input int i);
    real a;
    a = $atan(2.0 ** real'(-i)) * (2.0 ** real'(WIDTH)) / (2.0 * 3.14159265358979323846);
    return WIDTH'($rtoi(a + 0.5));
  endfunction

  // clamp the extended datapath back into WIDTH bits
  function automatic logic [WIDTH-1:0] sat(input logic [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == {3{v[XW-1]}}) return v[WIDTH-1:0];
    return v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    mode_q;
  logic signed [XW-1:0]    xr, yr;
  logic signed [WIDTH-1:0] zr;

  logic signed [WIDTH-1:0] atan_rom [ITERS];
  for (genvar g = 0; g < ITERS; g++) begin : g_rom
    assign atan_rom[g] = atan_val(g);
  end

  // quadrant pre-rotation on the raw operands
  logic signed [XW-1:0]    xe, ye, xp, yp;
  logic signed [WIDTH-1:0] zp;
  assign xe = {{2{x_in[WIDTH-1]}}, x_in};
  assign ye = {{2{y_in[WIDTH-1]}}, y_in};

  always_comb begin
    xp = xe;
    yp = ye;
    zp = z_in;
    if (!mode) begin
      if (z_in >= HALF_PI) begin
        xp = -ye; yp = xe;  zp = z_in - HALF_PI;
      end else if (z_in < -HALF_PI) begin
        xp = ye;  yp = -xe; zp = z_in + HALF_PI;
      end
    end else if (xe[XW-1]) begin
      if (!ye[XW-1]) begin
        xp = ye;  yp = -xe; zp = z_in + HALF_PI;
      end else begin
        xp = -ye; yp = xe;  zp = z_in - HALF_PI;
      end
    end
  end

  // UNROLL micro-rotations chained combinationally from the state registers
  logic [UNROLL:0][XW-1:0]    xc, yc;
  logic [UNROLL:0][WIDTH-1:0] zc;
  logic [UNROLL-1:0][CW-1:0]  idx;
  assign xc[0] = xr;
  assign yc[0] = yr;
  assign zc[0] = zr;

  for (genvar u = 0; u < UNROLL; u++) begin : g_stage
    assign idx[u] = cnt + CW'(u);
    cordic_iter_stage #(.WIDTH(WIDTH), .SW(CW)) u_stage (
      .mode (mode_q),
      .sh   (idx[u]),
      .atan (atan_rom[idx[u]]),
      .x_i  (xc[u]),
      .y_i  (yc[u]),
      .z_i  (zc[u]),
      .x_o  (xc[u+1]),
      .y_o  (yc[u+1]),
      .z_o  (zc[u+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          xr     <= xp;
          yr     <= yp;
          zr     <= zp;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          xr  <= xc[UNROLL];
          yr  <= yc[UNROLL];
          zr  <= zc[UNROLL];
          cnt <= cnt + CW'(UNROLL);
          if (cnt == CW'(ITERS - UNROLL)) begin
            x_out <= sat(xc[UNROLL]);
            y_out <= sat(yc[UNROLL]);
            z_out <= zc[UNROLL];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start during the done cycle is dropped
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: table of operand sets with expectations from
// real-valued trig (scaled by K), scoreboard queue, plus hand-written handshake,
// unroll-latency and mid-run reset sequences. Three instances (UNROLL 2/1/4)
// share one set of inputs.
module tb_cordic_iter_engine;
  localparam int    W     = 18;
  localparam real   PI    = 3.14159265358979323846;
  localparam real   ZSCL  = 262144.0;  // 2^W
  localparam int    TOLZ  = 40;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic busy2, done2, busy1, done1, busy4, done4;
  logic signed [W-1:0] x2, y2, z2, x1, y1, z1, x4, y4, z4;

  always #5 clk = ~clk;

  cordic_iter_engine #(.WIDTH(W), .ITERS(12), .UNROLL(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .x_in(x_in), .y_in(y_in),
    .z_in(z_in), .busy(busy2), .done(done2), .x_out(x2), .y_out(y2), .z_out(z2));
  cordic_iter_engine #(.WIDTH(W), .ITERS(12), .UNROLL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .x_in(x_in), .y_in(y_in),
    .z_in(z_in), .busy(busy1), .done(done1), .x_out(x1), .y_out(y1), .z_out(z1));
  cordic_iter_engine #(.WIDTH(W), .ITERS(12), .UNROLL(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .x_in(x_in), .y_in(y_in),
    .z_in(z_in), .busy(busy4), .done(done4), .x_out(x4), .y_out(y4), .z_out(z4));

  typedef struct {
    bit m;
    int x, y, z;
    int ex, ey, ez, txy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   dcnt2 = 0, dcnt_all = 0;
  real  K;

  always @(posedge clk) begin
    dcnt2    <= dcnt2 + int'(done2);
    dcnt_all <= dcnt_all + int'(done1) + int'(done2) + int'(done4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp, int tol);
    n_vec++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // angle compare modulo 2*pi
  task automatic chk_z(string nm, logic signed [W-1:0] act, int exp);
    logic signed [W-1:0] d;
    d = act - W'(exp);
    n_vec++;
    if (int'(d) > TOLZ || int'(d) < -TOLZ) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d mod 2^%0d (tol %0d)", nm, act, exp, W, TOLZ);
    end
  endtask

  task automatic chk_res(string nm, logic signed [W-1:0] xo, logic signed [W-1:0] yo,
                         logic signed [W-1:0] zo, vec_t v);
    chk({nm, " x"}, int'(xo), v.ex, v.txy);
    chk({nm, " y"}, int'(yo), v.ey, v.txy);
    chk_z({nm, " z"}, zo, v.ez);
  endtask

  function automatic int rnd(real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int clampr(real r);
    if (r > 131071.0) return 131071;
    if (r < -131072.0) return -131072;
    return rnd(r);
  endfunction

  function automatic vec_t mk(bit m, int x, int y, int z);
    vec_t v;
    real a, xr, yr, zr, mag;
    v.m = m; v.x = x; v.y = y; v.z = z;
    a   = real'(z) * 2.0 * PI / ZSCL;
    mag = K * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    if (!m) begin
      xr = K * (real'(x) * $cos(a) - real'(y) * $sin(a));
      yr = K * (real'(x) * $sin(a) + real'(y) * $cos(a));
      zr = 0.0;
    end else begin
      xr = mag;
      yr = 0.0;
      zr = real'(z) + $atan2(real'(y), real'(x)) * ZSCL / (2.0 * PI);
    end
    v.ex  = clampr(xr);
    v.ey  = clampr(yr);
    v.ez  = rnd(zr);
    // residual angle after 12 iterations is ~2^-11 rad, so allow error ~ mag/1024
    v.txy = 12 + $rtoi(mag / 1024.0);
    return v;
  endfunction

  task automatic drive(vec_t v);
    mode = v.m;
    x_in = W'(v.x);
    y_in = W'(v.y);
    z_in = W'(v.z);
  endtask

  // start sampled on the next edge, then operands scrambled to prove capture
  task automatic issue(vec_t v);
    drive(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = ~v.m;
    x_in  = W'(12345);
    y_in  = W'(-777);
    z_in  = W'(40000);
    sb.push_back(v);
  endtask

  task automatic wait_done(string nm);
    int   t;
    vec_t v;
    t = 0;
    while (!done2 && t < 20) begin
      tick();
      t++;
    end
    v = sb.pop_front();
    if (!done2) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: done not seen within 20 cycles", nm);
    end else begin
      chk({nm, " lat"}, t, 6, 0);
      chk_res(nm, x2, y2, z2, v);
    end
  endtask

  initial begin
    int   c0, l1, l2, l4;
    logic signed [W-1:0] rx1, ry1, rz1, rx2, ry2, rz2, rx4, ry4, rz4;

    K = 1.0;
    for (int i = 0; i < 12; i++) K = K * $sqrt(1.0 + 2.0 ** real'(-2 * i));

    tbl.push_back(mk(1'b0,  32768,      0,   32768));  // pi/4
    tbl.push_back(mk(1'b0,  32768,      0,   98304));  // 3pi/4, pre-rotated
    tbl.push_back(mk(1'b1, -32768, -32768,       0));  // third quadrant
    tbl.push_back(mk(1'b1, 120000, 120000,       0));  // x saturates high
    tbl.push_back(mk(1'b0,  20000,  10000, -100000));  // z < -pi/2
    tbl.push_back(mk(1'b1, -30000,  20000,    1000));  // x<0, y>=0
    tbl.push_back(mk(1'b0,      0, -40000,       0));
    tbl.push_back(mk(1'b0,  50000,  50000, -131072));  // z = -pi
    tbl.push_back(mk(1'b0,-100000,      0,       0));  // x saturates low

    // reset state
    tick(); tick();
    chk("rst busy", int'(busy2), 0, 0);
    chk("rst done", int'(done2), 0, 0);
    chk("rst x_out", int'(x2), 0, 0);
    chk("rst y_out", int'(y2), 0, 0);
    chk("rst z_out", int'(z2), 0, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i]);
      wait_done($sformatf("vec%0d", i));
      tick();
    end

    // handshake: start while busy and during the done cycle are both dropped
    repeat (16) tick();
    c0 = dcnt2;
    issue(tbl[0]);                                   // edge T0
    chk("hs busy T0+1", int'(busy2), 1, 0);
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;              // edge T0+3, ignored
    tick(); tick();
    chk("hs done T0+5", int'(done2), 0, 0);
    tick();
    chk("hs done T0+6", int'(done2), 1, 0);
    chk("hs busy T0+6", int'(busy2), 1, 0);
    chk_res("hs op1", x2, y2, z2, sb.pop_front());
    drive(tbl[1]);
    start = 1'b1;
    tick();                                          // edge T0+7, DONE: ignored
    chk("hs busy T0+7", int'(busy2), 0, 0);
    chk("hs done T0+7", int'(done2), 0, 0);
    tick();                                          // edge T0+8, accepted
    start = 1'b0;
    sb.push_back(tbl[1]);
    chk("hs busy T0+8", int'(busy2), 1, 0);
    repeat (5) tick();
    chk("hs done T0+13", int'(done2), 0, 0);
    tick();
    chk("hs done T0+14", int'(done2), 1, 0);
    chk_res("hs op2", x2, y2, z2, sb.pop_front());
    tick();
    chk("hs busy idle", int'(busy2), 0, 0);
    chk("hs done count", dcnt2 - c0, 2, 0);

    // latency per unroll factor, same operands on all three instances
    repeat (4) tick();
    l1 = -1; l2 = -1; l4 = -1;
    drive(tbl[0]);
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done1 && l1 < 0) begin l1 = t; rx1 = x1; ry1 = y1; rz1 = z1; end
      if (done2 && l2 < 0) begin l2 = t; rx2 = x2; ry2 = y2; rz2 = z2; end
      if (done4 && l4 < 0) begin l4 = t; rx4 = x4; ry4 = y4; rz4 = z4; end
    end
    chk("lat unroll1", l1, 12, 0);
    chk("lat unroll2", l2, 6, 0);
    chk("lat unroll4", l4, 3, 0);
    if (l1 > 0) chk_res("u1", rx1, ry1, rz1, tbl[0]);
    if (l2 > 0) chk_res("u2", rx2, ry2, rz2, tbl[0]);
    if (l4 > 0) chk_res("u4", rx4, ry4, rz4, tbl[0]);

    // reset mid-run: immediate clear, no done pulse afterwards
    drive(tbl[2]);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst busy2", int'(busy2), 0, 0);
    chk("mrst busy1", int'(busy1), 0, 0);
    chk("mrst done2", int'(done2), 0, 0);
    chk("mrst x_out", int'(x2), 0, 0);
    chk("mrst y_out", int'(y2), 0, 0);
    chk("mrst z_out", int'(z2), 0, 0);
    tick(); tick();
    c0 = dcnt_all;
    rst_n = 1'b1;
    repeat (16) tick();
    chk("mrst no done", dcnt_all - c0, 0, 0);
    chk("mrst busy idle", int'(busy4), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
